// File: rtl/vga_pkg.sv
// Shared timing defaults, colour types and the 8-bit to 12-bit colour expansion
// used by the VGA scan controller.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef struct packed {
      logic [2:0] red;
      logic [2:0] green;
      logic [1:0] blue;
   } rgb8_t;

   typedef struct packed {
      logic [3:0] red;
      logic [3:0] green;
      logic [3:0] blue;
   } rgb12_t;

   // Replicate the top bits so full-scale 8-bit colour maps to 4'hF
   function automatic rgb12_t expand_rgb8(input rgb8_t i_color);
      rgb12_t w_out;
      w_out.red   = {i_color.red, i_color.red[2]};
      w_out.green = {i_color.green, i_color.green[2]};
      w_out.blue  = {i_color.blue, i_color.blue};
      return w_out;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset value, used to align
// timing signals with the colour pipeline.
module vga_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stages [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stages[i] <= RESET_VALUE;
         end
      end else begin
         r_stages[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_stages[i] <= r_stages[i-1];
         end
      end
   end

   assign o_data = r_stages[DEPTH-1];

endmodule

// File: rtl/vga_scan_controller.sv
// Raster counters, sync generation and colour output for the billiard display.
// Define VGA_TEST_PATTERN_EN to replace RGBIn with eight vertical colour bars.
module vga_scan_controller
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  RGBIn,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic [3:0]  VGA_R,
   output logic [3:0]  VGA_G,
   output logic [3:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS
);

   localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST       = 11'(LINE_LEN - 1);
   localparam logic [10:0] V_LAST       = 11'(FRAME_LINES - 1);
   localparam logic [10:0] H_VISIBLE    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VISIBLE    = 11'(V_ACTIVE);
   localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] V_SYNC_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] r_hCount;
   logic [10:0] r_vCount;
   logic        r_startOfFrame;
   logic [3:0]  r_vgaR;
   logic [3:0]  r_vgaG;
   logic [3:0]  r_vgaB;
   logic        r_vgaHs;
   logic        r_vgaVs;

   logic        w_hWrap;
   logic        w_vWrap;
   logic        w_active;
   logic        w_hsRaw;
   logic        w_vsRaw;
   logic [2:0]  w_timingDly;
   rgb12_t      w_color;

   assign w_hWrap = (r_hCount == H_LAST);
   assign w_vWrap = (r_vCount == V_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hCount <= '0;
         r_vCount <= '0;
      end else if (w_hWrap) begin
         r_hCount <= '0;
         r_vCount <= w_vWrap ? 11'd0 : r_vCount + 11'd1;
      end else begin
         r_hCount <= r_hCount + 11'd1;
      end
   end

   // Registered so the pulse lands in the cycle the counters read (0,0) after a wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         r_startOfFrame <= 1'b0;
      end else begin
         r_startOfFrame <= w_hWrap && w_vWrap;
      end
   end

   assign w_active = (r_hCount < H_VISIBLE) && (r_vCount < V_VISIBLE);
   assign w_hsRaw  = !((r_hCount >= H_SYNC_FIRST) && (r_hCount <= H_SYNC_LAST));
   assign w_vsRaw  = !((r_vCount >= V_SYNC_FIRST) && (r_vCount <= V_SYNC_LAST));

   vga_delay_line #(
      .WIDTH       (3),
      .DEPTH       (PIPE_DELAY),
      .RESET_VALUE (3'b011)
   ) u_timingDelay (
      .i_clk   (clk),
      .i_reset (reset),
      .i_data  ({w_active, w_hsRaw, w_vsRaw}),
      .o_data  (w_timingDly)
   );

`ifdef VGA_TEST_PATTERN_EN
   logic [10:0] w_pixelXDly;
   logic [10:0] w_barWide;
   logic [2:0]  w_bar;

   vga_delay_line #(
      .WIDTH       (11),
      .DEPTH       (PIPE_DELAY),
      .RESET_VALUE (11'd0)
   ) u_pixelXDelay (
      .i_clk   (clk),
      .i_reset (reset),
      .i_data  (r_hCount),
      .o_data  (w_pixelXDly)
   );

   // Bar index is x/80, so bar 0 is black and bar 7 white
   assign w_barWide     = w_pixelXDly / 11'd80;
   assign w_bar         = w_barWide[2:0];
   assign w_color.red   = {4{w_bar[2]}};
   assign w_color.green = {4{w_bar[1]}};
   assign w_color.blue  = {4{w_bar[0]}};
`else
   assign w_color = expand_rgb8(rgb8_t'(RGBIn));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vgaR  <= '0;
         r_vgaG  <= '0;
         r_vgaB  <= '0;
         r_vgaHs <= 1'b1;
         r_vgaVs <= 1'b1;
      end else begin
         r_vgaR  <= w_timingDly[2] ? w_color.red   : 4'h0;
         r_vgaG  <= w_timingDly[2] ? w_color.green : 4'h0;
         r_vgaB  <= w_timingDly[2] ? w_color.blue  : 4'h0;
         r_vgaHs <= w_timingDly[1];
         r_vgaVs <= w_timingDly[0];
      end
   end

   assign pixelX       = r_hCount;
   assign pixelY       = r_vCount;
   assign startOfFrame = r_startOfFrame;
   assign VGA_R        = r_vgaR;
   assign VGA_G        = r_vgaG;
   assign VGA_B        = r_vgaB;
   assign VGA_HS       = r_vgaHs;
   assign VGA_VS       = r_vgaVs;

endmodule
